map_data_structure_registered: RTL

//  Registered successor to the combinational-lookup key/value map. Stores up to MAP_SIZE entries
//  and executes INSERT / DELETE / LOOKUP / CLEAR requests through a valid/ready request port.

---
 rtl/map_data_structure_registered.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/map_data_structure_registered.sv
`default_nettype none
// ============================================================================
// Module   : map_data_structure_registered
// Purpose  : Key/value map with up to MAP_SIZE entries. Requests (CLEAR,
//            INSERT, DELETE, LOOKUP) enter through a valid/ready port. Each
//            accepted request produces exactly one registered response that
//            carries a status, a value and a slot index. The response stage
//            is one entry deep and supports consumer back-pressure.
// Ports    : clk, reset_n (async, active low)
//            req_valid/req_ready/req_op/req_key/req_value   request port
//            resp_valid/resp_ready/resp_status/resp_value/resp_index
//                                                            response port
//            count/full/empty                                occupancy
// Revision : 1.0  initial release
// ============================================================================
module map_data_structure_registered #(
  parameter  int KEY_WIDTH   = 8,
  parameter  int VALUE_WIDTH = 16,
  parameter  int MAP_SIZE    = 16,
  localparam int IDX_W       = $clog2(MAP_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [2:0]             resp_status,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output logic [IDX_W-1:0]       resp_index,
  output logic [IDX_W:0]         count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [1:0] OP_CLEAR  = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;
  localparam logic [1:0] OP_LOOKUP = 2'd3;

  localparam logic [2:0] ST_HIT      = 3'd0;
  localparam logic [2:0] ST_MISS     = 3'd1;
  localparam logic [2:0] ST_INSERTED = 3'd2;
  localparam logic [2:0] ST_UPDATED  = 3'd3;
  localparam logic [2:0] ST_DELETED  = 3'd4;
  localparam logic [2:0] ST_FULL     = 3'd5;
  localparam logic [2:0] ST_CLEARED  = 3'd6;

  // Entry storage
  logic [MAP_SIZE-1:0]    valid_q, valid_d;
  logic [KEY_WIDTH-1:0]   key_q [MAP_SIZE];
  logic [VALUE_WIDTH-1:0] val_q [MAP_SIZE];
  logic [IDX_W:0]         count_q, count_d;

  // Response stage
  logic                   resp_valid_q, resp_valid_d;
  logic [2:0]             resp_status_q, resp_status_d;
  logic [VALUE_WIDTH-1:0] resp_value_q, resp_value_d;
  logic [IDX_W-1:0]       resp_index_q, resp_index_d;

  // Entry write port (key and value written together)
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_idx;

  // Lookup results
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic [VALUE_WIDTH-1:0] hit_value;
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic                   accept;

  // The output stage can take a new response when it is empty or is being
  // drained on this same edge.
  assign req_ready = ~resp_valid_q | resp_ready;
  assign accept    = req_valid & req_ready;

  // Keys are unique among valid entries, so at most one slot matches.
  // The free-slot search walks downward so the lowest free index wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < MAP_SIZE; i++) begin
      if (valid_q[i] && (key_q[i] == req_key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    for (int i = MAP_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign hit_value = val_q[hit_idx];

  always_comb begin
    valid_d       = valid_q;
    count_d       = count_q;
    wr_en         = 1'b0;
    wr_idx        = '0;
    resp_valid_d  = resp_valid_q;
    resp_status_d = resp_status_q;
    resp_value_d  = resp_value_q;
    resp_index_d  = resp_index_q;

    if (accept) begin
      resp_valid_d = 1'b1;
      resp_value_d = '0;
      resp_index_d = '0;
      case (req_op)
        OP_CLEAR: begin
          valid_d       = '0;
          count_d       = '0;
          resp_status_d = ST_CLEARED;
        end
        OP_INSERT: begin
          if (hit) begin
            wr_en         = 1'b1;
            wr_idx        = hit_idx;
            resp_status_d = ST_UPDATED;
            resp_value_d  = hit_value;
            resp_index_d  = hit_idx;
          end else if (free_found) begin
            wr_en             = 1'b1;
            wr_idx            = free_idx;
            valid_d[free_idx] = 1'b1;
            count_d           = count_q + 1'b1;
            resp_status_d     = ST_INSERTED;
            resp_index_d      = free_idx;
          end else begin
            resp_status_d = ST_FULL;
          end
        end
        OP_DELETE: begin
          if (hit) begin
            // Stale key/value stay in the slot; only the valid bit drops.
            valid_d[hit_idx] = 1'b0;
            count_d          = count_q - 1'b1;
            resp_status_d    = ST_DELETED;
            resp_value_d     = hit_value;
            resp_index_d     = hit_idx;
          end else begin
            resp_status_d = ST_MISS;
          end
        end
        OP_LOOKUP: begin
          if (hit) begin
            resp_status_d = ST_HIT;
            resp_value_d  = hit_value;
            resp_index_d  = hit_idx;
          end else begin
            resp_status_d = ST_MISS;
          end
        end
        default: resp_status_d = ST_MISS;
      endcase
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d  = 1'b0;
      resp_status_d = '0;
      resp_value_d  = '0;
      resp_index_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q       <= '0;
      count_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      resp_value_q  <= '0;
      resp_index_q  <= '0;
      for (int i = 0; i < MAP_SIZE; i++) begin
        key_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      count_q       <= count_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_value_q  <= resp_value_d;
      resp_index_q  <= resp_index_d;
      if (wr_en) begin
        key_q[wr_idx] <= req_key;
        val_q[wr_idx] <= req_value;
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign resp_value  = resp_value_q;
  assign resp_index  = resp_index_q;
  assign count       = count_q;
  assign full        = (count_q == (IDX_W + 1)'(MAP_SIZE));
  assign empty       = (count_q == '0);

endmodule
`default_nettype wire
